// File: rtl/smg_arb_pkg.sv
// -----------------------------------------------------------------------------
// smg_arb_pkg
// Shared types and constants for the SMG memory arbiter: FSM state encoding,
// requester port indices, default bus widths and the lock-owner record.
// -----------------------------------------------------------------------------
package smg_arb_pkg;

    // Default bus widths for the 64Kx8 SMG memory.
    localparam int SMG_ADDR_W = 16;
    localparam int SMG_DATA_W = 8;

    // Requester port indices.
    localparam int P_CPU  = 0;   // CPU datapath
    localparam int P_LOAD = 1;   // loader / debug port

    // Arbiter FSM: one access takes IDLE -> ISSUE -> DONE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    // Which port (if any) currently holds the lock.
    typedef struct packed {
        logic vld;   // a port holds the lock
        logic own;   // index of the owning port
    } lock_owner_t;

    // One-hot grant vector for a port index.
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : smg_arb_pkg

// File: rtl/smg_arb_pick.sv
// -----------------------------------------------------------------------------
// smg_arb_pick
// Combinational winner selection for the two-port SMG memory arbiter.
// A lock owner that requests again keeps the memory while its consecutive
// locked-grant count is below MAX_LOCK; otherwise a sole requester wins, and
// on a tie the port that did not win last time gets the memory.
// -----------------------------------------------------------------------------
module smg_arb_pick
    import smg_arb_pkg::*;
#(
    parameter int MAX_LOCK = 4,
    parameter int CNT_W    = 3
) (
    input  logic [1:0]       req_i,       // per-port request
    input  logic             ptr_i,       // index of the last winner
    input  lock_owner_t      lock_i,      // current lock owner
    input  logic [CNT_W-1:0] lock_cnt_i,  // consecutive locked grants so far
    output logic [1:0]       gnt_o,       // one-hot winner (0 when no request)
    output logic             lock_hit_o   // winner chosen by the lock rule
);

    logic lock_ok;

    // The lock applies only while its owner still requests and has budget left.
    always_comb begin
        lock_ok = lock_i.vld && req_i[lock_i.own] && (lock_cnt_i < CNT_W'(MAX_LOCK));
    end

    // Pick the winner: lock first, then single requester, then round-robin.
    always_comb begin
        // NOTE: every output gets a default before the branches so no latch is inferred.
        gnt_o      = 2'b00;
        lock_hit_o = 1'b0;
        if (lock_ok) begin
            gnt_o      = port_onehot(lock_i.own);
            lock_hit_o = 1'b1;
        end else begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = port_onehot(~ptr_i);
                default: gnt_o = 2'b00;
            endcase
        end
    end

endmodule : smg_arb_pick

// File: rtl/smg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// smg_mem_arbiter
// Shares the SMG single-port 64Kx8 memory between the CPU datapath (port 0)
// and the loader/debug port (port 1). Each access runs IDLE -> ISSUE -> DONE:
// the winner's command is registered in IDLE, driven to the memory in ISSUE,
// and acknowledged in DONE together with the 1-cycle synchronous read data.
// Round-robin arbitration with a bounded lock lets the CPU keep the memory
// for multi-byte fetches without starving the loader.
//
// Optional feature: define SMG_ARB_STATS_EN to build saturating grant and
// contention counters; without it the stat_* outputs are tied to zero.
// -----------------------------------------------------------------------------
module smg_mem_arbiter
    import smg_arb_pkg::*;
#(
    parameter int ADDR_W   = SMG_ADDR_W,
    parameter int DATA_W   = SMG_DATA_W,
    parameter int MAX_LOCK = 4,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    // requester side
    input  logic [1:0]        req_i,
    input  logic [1:0]        lock_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        gnt_o,
    output logic              busy_o,
    // memory side
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // statistics
    output logic [STAT_W-1:0] stat_gnt0_o,
    output logic [STAT_W-1:0] stat_gnt1_o,
    output logic [STAT_W-1:0] stat_conf_o
);

    // Lock counter must hold values 0..MAX_LOCK.
    localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    arb_state_e        state_q,    state_d;
    logic              ptr_q,      ptr_d;       // index of the last winner
    lock_owner_t       lock_q,     lock_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]        gnt_q,      gnt_d;
    logic [1:0]        ack_q,      ack_d;
    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;

    // Winner selection
    logic [1:0]        pick_gnt;
    logic              pick_lock_hit;
    logic              win;

    smg_arb_pick #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_pick (
        .req_i      (req_i),
        .ptr_i      (ptr_q),
        .lock_i     (lock_q),
        .lock_cnt_i (lock_cnt_q),
        .gnt_o      (pick_gnt),
        .lock_hit_o (pick_lock_hit)
    );

    assign win = pick_gnt[P_LOAD];

    // ---------------------------------------------------------------------
    // Next-state logic for the access FSM, command registers and lock
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = gnt_q;
        ack_d      = 2'b00;
        mem_we_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            IDLE: begin
                // An owner that stops requesting gives the lock up.
                if (lock_q.vld && !req_i[lock_q.own]) begin
                    lock_d     = '0;
                    lock_cnt_d = '0;
                end
                if (req_i != 2'b00) begin
                    gnt_d    = pick_gnt;
                    mem_we_d = we_i[win];
                    addr_d   = win ? addr1_i  : addr0_i;
                    wdata_d  = win ? wdata1_i : wdata0_i;
                    // The lock follows the winner's hint at grant time; the
                    // count only grows on grants that the lock itself won.
                    if (lock_i[win]) begin
                        lock_d.vld = 1'b1;
                        lock_d.own = win;
                        lock_cnt_d = pick_lock_hit ? (lock_cnt_q + CNT_W'(1)) : '0;
                    end else begin
                        lock_d     = '0;
                        lock_cnt_d = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Memory samples the command now; ack lands with its read data.
                ack_d   = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                ptr_d   = gnt_q[P_LOAD];
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register FSM state, command and outputs; reset abandons any access.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'(P_LOAD);
            lock_q     <= '0;
            lock_cnt_q <= '0;
            gnt_q      <= 2'b00;
            ack_q      <= 2'b00;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign ack_o       = ack_q;
    assign gnt_o       = gnt_q;
    assign busy_o      = (state_q != IDLE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    // Read data is only meaningful alongside an ack; keep it quiet otherwise.
    assign rdata_o     = (ack_q != 2'b00) ? mem_rdata_i : '0;

    // ---------------------------------------------------------------------
    // Statistics
    // ---------------------------------------------------------------------
`ifdef SMG_ARB_STATS_EN
    logic [STAT_W-1:0] stat_gnt0_q, stat_gnt0_d;
    logic [STAT_W-1:0] stat_gnt1_q, stat_gnt1_d;
    logic [STAT_W-1:0] stat_conf_q, stat_conf_d;

    // Saturating counters: completed grants per port and contested IDLE cycles.
    always_comb begin
        stat_gnt0_d = stat_gnt0_q;
        stat_gnt1_d = stat_gnt1_q;
        stat_conf_d = stat_conf_q;
        if (state_q == DONE && gnt_q[P_CPU] && stat_gnt0_q != '1) begin
            stat_gnt0_d = stat_gnt0_q + STAT_W'(1);
        end
        if (state_q == DONE && gnt_q[P_LOAD] && stat_gnt1_q != '1) begin
            stat_gnt1_d = stat_gnt1_q + STAT_W'(1);
        end
        if (state_q == IDLE && req_i == 2'b11 && stat_conf_q != '1) begin
            stat_conf_d = stat_conf_q + STAT_W'(1);
        end
    end

    // Register the statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_gnt0_q <= '0;
            stat_gnt1_q <= '0;
            stat_conf_q <= '0;
        end else begin
            stat_gnt0_q <= stat_gnt0_d;
            stat_gnt1_q <= stat_gnt1_d;
            stat_conf_q <= stat_conf_d;
        end
    end

    assign stat_gnt0_o = stat_gnt0_q;
    assign stat_gnt1_o = stat_gnt1_q;
    assign stat_conf_o = stat_conf_q;
`else
    assign stat_gnt0_o = '0;
    assign stat_gnt1_o = '0;
    assign stat_conf_o = '0;
`endif

endmodule : smg_mem_arbiter

// File: tb/tb_smg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_smg_mem_arbiter
// Directed bench for smg_mem_arbiter. Per-port drivers present queued
// commands and hold them until ack; expected responses are queued when the
// stimulus is issued and a monitor compares them against every ack.
// Built with STAT_W=4 so counter saturation is reachable; the statistics
// expectations follow SMG_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_smg_mem_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int MAX_LOCK = 4;
    localparam int STAT_W   = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              lock;
    } cmd_t;

    typedef struct {
        int                port;
        logic              is_rd;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic              req_v  [2];
    logic              lock_v [2];
    logic              we_v   [2];
    logic [ADDR_W-1:0] addr_v [2];
    logic [DATA_W-1:0] wdata_v[2];

    logic [1:0]        req_i, lock_i, we_i;
    logic [1:0]        ack_o, gnt_o;
    logic [DATA_W-1:0] rdata_o, mem_wdata_o, mem_rdata;
    logic              busy_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [STAT_W-1:0] stat_gnt0_o, stat_gnt1_o, stat_conf_o;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    cmd_t cmd0_q[$];
    cmd_t cmd1_q[$];
    exp_t sb_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    assign req_i  = {req_v[1],  req_v[0]};
    assign lock_i = {lock_v[1], lock_v[0]};
    assign we_i   = {we_v[1],   we_v[0]};

    smg_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (MAX_LOCK),
        .STAT_W   (STAT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .we_i        (we_i),
        .addr0_i     (addr_v[0]),
        .wdata0_i    (wdata_v[0]),
        .addr1_i     (addr_v[1]),
        .wdata1_i    (wdata_v[1]),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .gnt_o       (gnt_o),
        .busy_o      (busy_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata),
        .stat_gnt0_o (stat_gnt0_o),
        .stat_gnt1_o (stat_gnt1_o),
        .stat_conf_o (stat_conf_o)
    );

    always #5 clk = ~clk;

    // Single-port memory with 1-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        mem_rdata <= mem[mem_addr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic push_cmd(input int p, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic lk);
        cmd_t c;
        c.addr = a; c.wdata = d; c.we = we; c.lock = lk;
        if (p == 0) cmd0_q.push_back(c); else cmd1_q.push_back(c);
    endtask

    task automatic push_exp(input int p, input logic rd, input logic [DATA_W-1:0] d);
        exp_t e;
        e.port = p; e.is_rd = rd; e.rdata = d;
        sb_q.push_back(e);
    endtask

    // Monitor: every ack must match the oldest expected response.
    always @(negedge clk) begin
        if (ack_o != 2'b00) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'(ack_o), 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_port", 32'(ack_o), 32'(onehot(mon_e.port)));
                check("gnt_at_ack", 32'(gnt_o), 32'(onehot(mon_e.port)));
                if (mon_e.is_rd) check("ack_rdata", 32'(rdata_o), 32'(mon_e.rdata));
            end
        end
    end

    // Port driver: present queued commands, hold each until its ack.
    task automatic run_port(input int p);
        cmd_t c;
        int   n;
        forever begin
            if ((p == 0 ? cmd0_q.size() : cmd1_q.size()) == 0) begin
                @(posedge clk); #1;
            end else begin
                c = (p == 0) ? cmd0_q[0] : cmd1_q[0];
                addr_v[p]  = c.addr;
                wdata_v[p] = c.wdata;
                we_v[p]    = c.we;
                lock_v[p]  = c.lock;
                req_v[p]   = 1'b1;
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!ack_o[p] && n < 64);
                if (!ack_o[p]) begin
                    checks++;
                    failures++;
                    $display("FAIL ack_timeout port %0d: got no ack, required one within 64 cycles", p);
                end
                if (p == 0) void'(cmd0_q.pop_front()); else void'(cmd1_q.pop_front());
                if ((p == 0 ? cmd0_q.size() : cmd1_q.size()) == 0) begin
                    req_v[p]  = 1'b0;
                    lock_v[p] = 1'b0;
                end
            end
        end
    endtask

    // Cycle-accurate single access, called at posedge+1 with the DUT in IDLE.
    task automatic directed(input int p, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd,
                            input string tag);
        push_exp(p, !we, exp_rd);
        check({tag, "_c0_mem_we"}, 32'(mem_we_o), 32'h0);
        addr_v[p] = a; wdata_v[p] = d; we_v[p] = we; lock_v[p] = 1'b0; req_v[p] = 1'b1;
        @(posedge clk); #1;   // ISSUE
        check({tag, "_c1_mem_addr"}, 32'(mem_addr_o), 32'(a));
        check({tag, "_c1_mem_we"}, 32'(mem_we_o), 32'(we));
        if (we) check({tag, "_c1_mem_wdata"}, 32'(mem_wdata_o), 32'(d));
        check({tag, "_c1_gnt"}, 32'(gnt_o), 32'(onehot(p)));
        check({tag, "_c1_busy"}, 32'(busy_o), 32'h1);
        check({tag, "_c1_ack"}, 32'(ack_o), 32'h0);
        @(posedge clk); #1;   // DONE
        check({tag, "_c2_ack"}, 32'(ack_o), 32'(onehot(p)));
        check({tag, "_c2_mem_we"}, 32'(mem_we_o), 32'h0);
        if (!we) check({tag, "_c2_rdata"}, 32'(rdata_o), 32'(exp_rd));
        req_v[p] = 1'b0;
        @(posedge clk); #1;   // back in IDLE
        check({tag, "_c3_gnt"}, 32'(gnt_o), 32'h0);
        check({tag, "_c3_busy"}, 32'(busy_o), 32'h0);
        check({tag, "_c3_ack"}, 32'(ack_o), 32'h0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || cmd0_q.size() != 0 || cmd1_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(sb_q.size() + cmd0_q.size() + cmd1_q.size()), 32'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},       32'(ack_o),       32'h0);
        check({tag, "_gnt"},       32'(gnt_o),       32'h0);
        check({tag, "_busy"},      32'(busy_o),      32'h0);
        check({tag, "_mem_we"},    32'(mem_we_o),    32'h0);
        check({tag, "_mem_addr"},  32'(mem_addr_o),  32'h0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata_o), 32'h0);
        check({tag, "_rdata"},     32'(rdata_o),     32'h0);
    endtask

    int seq4[8] = '{0, 0, 0, 0, 0, 1, 0, 1};

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; lock_v[i] = 1'b0; we_v[i] = 1'b0;
            addr_v[i] = '0;  wdata_v[i] = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        check("rst_stat_gnt0", 32'(stat_gnt0_o), 32'h0);
        check("rst_stat_gnt1", 32'(stat_gnt1_o), 32'h0);
        check("rst_stat_conf", 32'(stat_conf_o), 32'h0);
        reset = 1'b0;

        // Preload 0x1234 = 0xA5, then port 0 reads it back with exact timing.
        directed(1, 1'b1, 16'h1234, 8'hA5, 8'h00, "pre_wr");
        directed(0, 1'b0, 16'h1234, 8'h00, 8'hA5, "p0_rd");
        // Port 1 writes the top address, then reads it back.
        directed(1, 1'b1, 16'hFFFF, 8'h5A, 8'h00, "p1_wr");
        directed(1, 1'b0, 16'hFFFF, 8'h00, 8'h5A, "p1_rd");

        fork
            run_port(0);
            run_port(1);
        join_none

        // Both ports requesting without lock: strict alternation, port 0 first.
        reset_pulse();
        #2;
        for (int i = 0; i < 3; i++) begin
            push_cmd(0, 1'b0, 16'h1234, 8'h00, 1'b0);
            push_cmd(1, 1'b0, 16'hFFFF, 8'h00, 1'b0);
            push_exp(0, 1'b1, 8'hA5);
            push_exp(1, 1'b1, 8'h5A);
        end
        wait_drain("drain_rr");

        // Port 0 locked for 6 accesses against a busy port 1: lock budget of 4.
        reset_pulse();
        #2;
        for (int i = 0; i < 6; i++) push_cmd(0, 1'b0, 16'h1234, 8'h00, 1'b1);
        for (int i = 0; i < 2; i++) push_cmd(1, 1'b0, 16'hFFFF, 8'h00, 1'b0);
        foreach (seq4[i]) push_exp(seq4[i], 1'b1, (seq4[i] == 0) ? 8'hA5 : 8'h5A);
        wait_drain("drain_lock");

        // Reset in the ISSUE cycle of a port-0 write.
        reset_pulse();
        addr_v[0] = 16'h0100; wdata_v[0] = 8'h77; we_v[0] = 1'b1; lock_v[0] = 1'b0; req_v[0] = 1'b1;
        @(posedge clk); #1;
        check("rst_issue_mem_we", 32'(mem_we_o), 32'h1);
        check("rst_issue_busy", 32'(busy_o), 32'h1);
        reset = 1'b1;
        req_v[0] = 1'b0; we_v[0] = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("rst_issue_after");
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_issue_no_late_ack", 32'(ack_o), 32'h0);
        check("rst_issue_idle_busy", 32'(busy_o), 32'h0);
        #2;
        push_cmd(0, 1'b0, 16'h1234, 8'h00, 1'b0);
        push_cmd(1, 1'b0, 16'hFFFF, 8'h00, 1'b0);
        push_exp(0, 1'b1, 8'hA5);
        push_exp(1, 1'b1, 8'h5A);
        wait_drain("drain_post_rst");

        // Long contested run: 17 grants per port, counters saturate at 15.
        reset_pulse();
        #2;
        for (int i = 0; i < 17; i++) begin
            push_cmd(0, 1'b0, 16'h1234, 8'h00, 1'b0);
            push_cmd(1, 1'b0, 16'hFFFF, 8'h00, 1'b0);
            push_exp(0, 1'b1, 8'hA5);
            push_exp(1, 1'b1, 8'h5A);
        end
        wait_drain("drain_stats");
`ifdef SMG_ARB_STATS_EN
        check("stat_gnt0_sat", 32'(stat_gnt0_o), 32'hF);
        check("stat_gnt1_sat", 32'(stat_gnt1_o), 32'hF);
        check("stat_conf_sat", 32'(stat_conf_o), 32'hF);
`else
        check("stat_gnt0_off", 32'(stat_gnt0_o), 32'h0);
        check("stat_gnt1_off", 32'(stat_gnt1_o), 32'h0);
        check("stat_conf_off", 32'(stat_conf_o), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_smg_mem_arbiter
